fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Sequences instruction fetch for the single-cycle/pipelined MIPS core: owns the PC, issues one word request at a time to instruction memory, and presents fetched words to decode over a valid/ready handshake.
- Applies branch/jump redirects from execute with priority over everything else.
- Flags misaligned or out-of-range PCs and halts fetch.
- Sits between the instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_BYTES, 28, instruction memory size in bytes; the highest legal fetch address is IMEM_BYTES-4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request, held until imem_ack.
- imem_addr  out  32  byte address of the word; equals pc at all times.
- imem_ack  in  1  memory has returned imem_rdata this cycle.
- imem_rdata  in  32  word, big-endian assembled: byte at addr is bits [31:24].
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  32  new PC.
- if_valid  out  1  if_instr/if_pc/if_pc_plus4 hold a fetched word.
- if_ready  in  1  decode accepts the word this cycle.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address of if_instr.
- if_pc_plus4  out  32  if_pc+4, modulo 2^32.
- fault  out  1  sticky fetch fault.

Behaviour:
Reset (asynchronous assert, synchronous release):
- pc=RESET_PC, state=IDLE.
- imem_req=0, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, fault=0.

States (enum in package): IDLE, REQ, HOLD, FAULT.

IDLE:
- Outputs idle.
- Next cycle goes to REQ, or takes a redirect if one is present.

REQ:
- If pc[1:0]!=0 or pc>IMEM_BYTES-4: imem_req=0, next state FAULT.
- Otherwise imem_req=1.
- On imem_ack:
  - Register if_instr=imem_rdata, if_pc=pc, if_pc_plus4=pc+4.
  - if_valid=1; pc<=pc+4; next state HOLD.
- Without ack: remain in REQ with imem_addr stable.

HOLD:
- if_valid=1, imem_req=0.
- On if_ready: if_valid<=0, next state REQ.
- Without if_ready: all if_* outputs are held stable.

FAULT:
- fault=1, imem_req=0, if_valid=0.
- Exit only via rst_n.

Latency and throughput:
- With zero-wait memory (ack in the first REQ cycle) and if_ready tied high: one instruction every 2 cycles.
- A word appears on if_* the cycle after ack.

Redirect (any state except FAULT) has highest priority:
- pc<=redirect_target, if_valid<=0 (an un-accepted word is flushed, even if if_ready is high the same cycle).
- An imem_ack arriving in the same cycle is discarded.
- Next state is REQ. imem_req may drop without ack; memory must tolerate request withdrawal.
- A misaligned or out-of-range target is detected in the following REQ cycle and leads to FAULT.
- redirect_valid in FAULT is ignored.

Width rules:
- pc+4 wraps modulo 2^32.
- The range check uses unsigned compare.

Reset mid-operation:
- An outstanding request is abandoned immediately.
- The memory must ignore an ack to a withdrawn request.

Decomposition:
- Package fetch_pkg holds:
  - state_t enum {IDLE, REQ, HOLD, FAULT};
  - ADDR_W=32, INSTR_W=32;
  - WORD_BYTES=4.
- Single module; no sub-module is natural. The PC register and the state machine live together.

Test Plan:
- Reset, IMEM_BYTES=28, memory acks same cycle, if_ready=1 -> if_pc sequence 0,4,8 on cycles 2,4,6 after release; words match memory bytes big-endian (bytes 12,34,56,78 -> 32'h12345678).
- Memory ack delayed 3 cycles -> imem_req held 4 cycles with imem_addr constant; exactly one if_valid pulse per word.
- if_ready=0 for 5 cycles in HOLD -> if_instr/if_pc stable, imem_req=0, no pc advance; fetch resumes the cycle after if_ready=1.
- redirect_valid with target 32'h10 in the same cycle as imem_ack for pc=8 -> word for 8 dropped; next request to 0x10; if_pc next shows 0x10.
- Sequential fetch reaches pc=24 then 28 -> word at 24 delivered, then fault=1, imem_req=0 permanently; redirect to 0 is ignored; rst_n low clears fault.
- redirect to 32'h6 -> one REQ cycle with imem_req=0, then FAULT; rst_n pulsed low mid-REQ -> all outputs to reset values immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
//   state_t    : fetch sequencer states
//   ADDR_W     : byte-address width
//   INSTR_W    : instruction word width
//   WORD_BYTES : bytes per instruction word (PC step)
//   pc_legal() : true when a PC is word aligned and within instruction memory
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int ADDR_W     = 32;
  localparam int INSTR_W    = 32;
  localparam int WORD_BYTES = 4;

  // max_pc is the highest fetchable word address; the compare is unsigned so
  // wrapped or very large targets are rejected rather than aliased.
  function automatic logic pc_legal(input logic [ADDR_W-1:0] pc,
                                    input logic [ADDR_W-1:0] max_pc);
    return (pc[1:0] == 2'b00) && (pc <= max_pc);
  endfunction

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one word request at a time
// to instruction memory and hands fetched words to decode over valid/ready.
// Redirects from execute override everything except a fault; a misaligned or
// out-of-range PC parks the block in a sticky fault until reset.
//
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   imem_req          : out, request for the word at imem_addr, held until ack
//   imem_addr         : out, byte address of the requested word (always the PC)
//   imem_ack          : in,  imem_rdata is valid this cycle
//   imem_rdata        : in,  fetched word, big-endian assembled
//   redirect_valid    : in,  taken branch/jump this cycle
//   redirect_target   : in,  new PC for the redirect
//   if_valid          : out, if_instr/if_pc/if_pc_plus4 hold a fetched word
//   if_ready          : in,  decode accepts the word this cycle
//   if_instr          : out, fetched instruction
//   if_pc             : out, address of if_instr
//   if_pc_plus4       : out, if_pc + 4 (mod 2^32)
//   fault             : out, sticky fetch fault
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 28
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic               fault
);

  localparam logic [ADDR_W-1:0] MAX_PC = ADDR_W'(IMEM_BYTES - WORD_BYTES);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(WORD_BYTES);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic                 if_valid_q, if_valid_d;
  logic [INSTR_W-1:0]   if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]    if_pc_q, if_pc_d;
  logic [ADDR_W-1:0]    if_pc_plus4_q, if_pc_plus4_d;
  logic                 pc_ok;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    imem_req      = 1'b0;
    pc_ok         = pc_legal(pc_q, MAX_PC);

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        // The PC is only checked when we are about to use it, so a bad
        // redirect target costs one request-less REQ cycle before FAULT.
        if (pc_ok) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            if_instr_d    = imem_rdata;
            if_pc_d       = pc_q;
            if_pc_plus4_d = pc_q + PC_STEP;
            if_valid_d    = 1'b1;
            pc_d          = pc_q + PC_STEP;
            state_d       = HOLD;
          end
        end else begin
          state_d = FAULT;
        end
      end
      HOLD: begin
        if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = REQ;
        end
      end
      FAULT: begin
        if_valid_d = 1'b0;
        state_d    = FAULT;
      end
      default: begin
        state_d = FAULT;
      end
    endcase

    // A redirect wins over ack, accept and fault detection. Any word returned
    // or still waiting for decode belongs to the wrong path and is dropped;
    // the if_* payload keeps its old value since if_valid goes low anyway.
    if (redirect_valid && (state_q != FAULT)) begin
      pc_d          = redirect_target;
      if_valid_d    = 1'b0;
      if_instr_d    = if_instr_q;
      if_pc_d       = if_pc_q;
      if_pc_plus4_d = if_pc_plus4_q;
      state_d       = REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign fault       = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a
// randomized run scored against a transaction-level model of the fetch stream.
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fault;

  int vectors;
  int miscompares;

  logic [7:0] mem [32];
  int         delay_cfg;
  bit         rand_delay;
  int         wait_left;

  fetch_controller #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(28)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  // Big-endian word assembly from the byte-addressed memory image.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    int base;
    base = int'(a[4:0]);
    w = {mem[base % 32], mem[(base + 1) % 32], mem[(base + 2) % 32], mem[(base + 3) % 32]};
    return w;
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'd24);
  endfunction

  function automatic int next_delay();
    if (rand_delay) return int'($urandom_range(0, 3));
    return delay_cfg;
  endfunction

  // Memory responder, called once per cycle at the falling edge: acks a
  // request after wait_left request cycles.
  task automatic mem_drive();
    if (imem_req === 1'b1) begin
      if (wait_left <= 0) begin
        imem_ack   = 1'b1;
        imem_rdata = word_at(imem_addr);
        wait_left  = next_delay();
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_left--;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
  endtask

  // Leaves time at the falling edge where rst_n was released (cycle 0).
  task automatic apply_reset();
    rst_n           = 1'b0;
    imem_ack        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    wait_left = next_delay();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 00000000", imem_addr); end
    vectors++; if ({if_valid, fault} !== 2'b00) begin miscompares++; $display("FAIL rst_valid_fault: got %b want 00", {if_valid, fault}); end
    vectors++; if ({if_instr, if_pc, if_pc_plus4} !== 96'h0) begin miscompares++; $display("FAIL rst_if: got %h want 0", {if_instr, if_pc, if_pc_plus4}); end
    // Inputs active while held in reset must not disturb anything.
    redirect_valid  = 1'b1;
    redirect_target = 32'h10;
    imem_ack        = 1'b1;
    if_ready        = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if ({imem_req, if_valid, fault, imem_addr} !== 35'h0) begin miscompares++; $display("FAIL rst_hold: got %h want 0", {imem_req, if_valid, fault, imem_addr}); end
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
  endtask

  task automatic test_seq_zero_wait();
    logic [31:0] p;
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    rand_delay = 1'b0; delay_cfg = 0; if_ready = 1'b1;
    apply_reset();
    for (int k = 1; k <= 6; k++) begin
      mem_drive();
      @(negedge clk);
      vectors++; if (if_valid !== ((k % 2) == 0)) begin miscompares++; $display("FAIL seq_valid c%0d: got %b want %b", k, if_valid, (k % 2) == 0); end
      if ((k % 2) == 0) begin
        p = 32'((k / 2 - 1) * 4);
        vectors++; if (if_pc !== p) begin miscompares++; $display("FAIL seq_pc c%0d: got %h want %h", k, if_pc, p); end
        vectors++; if (if_instr !== word_at(p)) begin miscompares++; $display("FAIL seq_instr c%0d: got %h want %h", k, if_instr, word_at(p)); end
        vectors++; if (if_pc_plus4 !== p + 32'd4) begin miscompares++; $display("FAIL seq_plus4 c%0d: got %h want %h", k, if_pc_plus4, p + 32'd4); end
        if (k == 2) begin
          vectors++; if (if_instr !== 32'h1234_5678) begin miscompares++; $display("FAIL seq_endian: got %h want 12345678", if_instr); end
        end
      end else begin
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL seq_req c%0d: got %b want 1", k, imem_req); end
      end
    end
  endtask

  task automatic test_wait_states();
    int phase;
    int pulses;
    logic [31:0] a;
    rand_delay = 1'b0; delay_cfg = 3; if_ready = 1'b1; pulses = 0;
    apply_reset();
    for (int k = 1; k <= 14; k++) begin
      mem_drive();
      @(negedge clk);
      phase = (k - 1) % 5;
      a = 32'(((k - 1) / 5) * 4);
      vectors++; if (imem_req !== (phase < 4)) begin miscompares++; $display("FAIL wait_req c%0d: got %b want %b", k, imem_req, phase < 4); end
      if (phase < 4) begin
        vectors++; if (imem_addr !== a) begin miscompares++; $display("FAIL wait_addr c%0d: got %h want %h", k, imem_addr, a); end
      end
      vectors++; if (if_valid !== (phase == 4)) begin miscompares++; $display("FAIL wait_valid c%0d: got %b want %b", k, if_valid, phase == 4); end
      if (if_valid === 1'b1) pulses++;
    end
    vectors++; if (pulses != 2) begin miscompares++; $display("FAIL wait_pulses: got %0d want 2", pulses); end
  endtask

  task automatic test_hold();
    logic [31:0] w;
    rand_delay = 1'b0; delay_cfg = 0; if_ready = 1'b0;
    apply_reset();
    repeat (2) begin mem_drive(); @(negedge clk); end
    w = word_at(32'h0);
    for (int i = 0; i < 5; i++) begin
      vectors++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, w}) begin miscompares++; $display("FAIL hold_stable i%0d: got %b/%h/%h want 1/00000000/%h", i, if_valid, if_pc, if_instr, w); end
      vectors++; if ({imem_req, imem_addr} !== {1'b0, 32'h4}) begin miscompares++; $display("FAIL hold_req i%0d: got %b/%h want 0/00000004", i, imem_req, imem_addr); end
      if (i == 4) if_ready = 1'b1;
      mem_drive();
      @(negedge clk);
    end
    vectors++; if ({if_valid, imem_req, imem_addr} !== {2'b01, 32'h4}) begin miscompares++; $display("FAIL hold_resume: got %b/%b/%h want 0/1/00000004", if_valid, imem_req, imem_addr); end
    mem_drive();
    @(negedge clk);
    vectors++; if ({if_valid, if_pc} !== {1'b1, 32'h4}) begin miscompares++; $display("FAIL hold_next: got %b/%h want 1/00000004", if_valid, if_pc); end
  endtask

  task automatic test_redirect_ack();
    rand_delay = 1'b0; delay_cfg = 0; if_ready = 1'b1;
    apply_reset();
    repeat (5) begin mem_drive(); @(negedge clk); end
    vectors++; if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin miscompares++; $display("FAIL redir_pre: got %b/%h want 1/00000008", imem_req, imem_addr); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h10;
    mem_drive();
    @(negedge clk);
    redirect_valid = 1'b0;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL redir_drop: got %b want 0", if_valid); end
    vectors++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin miscompares++; $display("FAIL redir_req: got %b/%h want 1/00000010", imem_req, imem_addr); end
    mem_drive();
    @(negedge clk);
    vectors++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h10, word_at(32'h10)}) begin miscompares++; $display("FAIL redir_word: got %b/%h/%h want 1/00000010/%h", if_valid, if_pc, if_instr, word_at(32'h10)); end
  endtask

  task automatic test_fault_end();
    logic [31:0] p;
    rand_delay = 1'b0; delay_cfg = 0; if_ready = 1'b1;
    apply_reset();
    for (int k = 1; k <= 16; k++) begin
      mem_drive();
      @(negedge clk);
      if ((k % 2) == 0 && k <= 14) begin
        p = 32'((k / 2 - 1) * 4);
        vectors++; if ({if_valid, if_pc} !== {1'b1, p}) begin miscompares++; $display("FAIL end_pc c%0d: got %b/%h want 1/%h", k, if_valid, if_pc, p); end
      end
      if (k == 15) begin
        vectors++; if ({imem_req, fault, imem_addr} !== {2'b00, 32'd28}) begin miscompares++; $display("FAIL end_noreq: got %b/%b/%h want 0/0/0000001c", imem_req, fault, imem_addr); end
      end
      if (k == 16) begin
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL end_fault: got %b want 1", fault); end
      end
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h0;
    for (int i = 0; i < 4; i++) begin
      mem_drive();
      @(negedge clk);
      redirect_valid = 1'b0;
      vectors++; if ({fault, imem_req, if_valid, imem_addr} !== {3'b100, 32'd28}) begin miscompares++; $display("FAIL end_sticky i%0d: got %b%b%b/%h want 100/0000001c", i, fault, imem_req, if_valid, imem_addr); end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({fault, imem_addr} !== {1'b0, 32'h0}) begin miscompares++; $display("FAIL end_clear: got %b/%h want 0/00000000", fault, imem_addr); end
  endtask

  task automatic test_misalign_and_reset();
    rand_delay = 1'b0; delay_cfg = 0; if_ready = 1'b1;
    apply_reset();
    repeat (2) begin mem_drive(); @(negedge clk); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h6;
    mem_drive();
    @(negedge clk);
    redirect_valid = 1'b0;
    vectors++; if ({imem_req, fault, if_valid, imem_addr} !== {3'b000, 32'h6}) begin miscompares++; $display("FAIL mis_req: got %b%b%b/%h want 000/00000006", imem_req, fault, if_valid, imem_addr); end
    mem_drive();
    @(negedge clk);
    vectors++; if ({fault, imem_req} !== 2'b10) begin miscompares++; $display("FAIL mis_fault: got %b%b want 10", fault, imem_req); end

    delay_cfg = 3;
    apply_reset();
    repeat (7) begin mem_drive(); @(negedge clk); end
    vectors++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin miscompares++; $display("FAIL mid_pre: got %b/%h want 1/00000004", imem_req, imem_addr); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({imem_req, if_valid, fault, imem_addr, if_instr, if_pc, if_pc_plus4} !== 131'h0) begin miscompares++; $display("FAIL mid_rst: got %b%b%b/%h/%h/%h/%h want all 0", imem_req, if_valid, fault, imem_addr, if_instr, if_pc, if_pc_plus4); end
    imem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    delay_cfg = 0;
    wait_left = 0;
    mem_drive();
    @(negedge clk);
    vectors++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL mid_restart: got %b/%h want 1/00000000", imem_req, imem_addr); end
    mem_drive();
    @(negedge clk);
    vectors++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, word_at(32'h0)}) begin miscompares++; $display("FAIL mid_word: got %b/%h/%h want 1/00000000/%h", if_valid, if_pc, if_instr, word_at(32'h0)); end
  endtask

  // Randomized run. The model only tracks the address the next delivered word
  // must carry: +4 per delivered word, replaced by any accepted redirect.
  task automatic test_random();
    logic [31:0] exp_pc, pv_instr, pv_pc, pv_plus4, tgt;
    bit prev_valid, prev_ready, prev_redir, prev_fault;
    int r;
    rand_delay = 1'b1;
    for (int ep = 0; ep < 6; ep++) begin
      apply_reset();
      exp_pc = 32'h0;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_redir = 1'b0; prev_fault = 1'b0;
      pv_instr = '0; pv_pc = '0; pv_plus4 = '0;
      for (int c = 0; c < 260; c++) begin
        if (prev_fault) begin
          vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL rnd_sticky e%0d c%0d: got %b want 1", ep, c, fault); end
        end
        if (fault === 1'b1) begin
          vectors++; if ({imem_req, if_valid} !== 2'b00) begin miscompares++; $display("FAIL rnd_fault_out e%0d c%0d: got %b%b want 00", ep, c, imem_req, if_valid); end
          if (!prev_fault) begin
            vectors++; if (legal(exp_pc)) begin miscompares++; $display("FAIL rnd_fault_cause e%0d c%0d: fault got 1 with legal pc %h, want 0", ep, c, exp_pc); end
          end
        end
        if (imem_req === 1'b1) begin
          vectors++; if (imem_addr !== exp_pc) begin miscompares++; $display("FAIL rnd_addr e%0d c%0d: got %h want %h", ep, c, imem_addr, exp_pc); end
        end
        if (prev_redir || (prev_valid && prev_ready)) begin
          vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_release e%0d c%0d: got %b want 0", ep, c, if_valid); end
        end else if (prev_valid) begin
          vectors++; if ({if_valid, if_instr, if_pc, if_pc_plus4} !== {1'b1, pv_instr, pv_pc, pv_plus4}) begin miscompares++; $display("FAIL rnd_hold e%0d c%0d: got %b/%h/%h want 1/%h/%h", ep, c, if_valid, if_pc, if_instr, pv_pc, pv_instr); end
        end else if (if_valid === 1'b1) begin
          vectors++; if (if_pc !== exp_pc) begin miscompares++; $display("FAIL rnd_pc e%0d c%0d: got %h want %h", ep, c, if_pc, exp_pc); end
          vectors++; if (if_instr !== word_at(exp_pc)) begin miscompares++; $display("FAIL rnd_instr e%0d c%0d: got %h want %h", ep, c, if_instr, word_at(exp_pc)); end
          vectors++; if (if_pc_plus4 !== exp_pc + 32'd4) begin miscompares++; $display("FAIL rnd_plus4 e%0d c%0d: got %h want %h", ep, c, if_pc_plus4, exp_pc + 32'd4); end
          exp_pc = exp_pc + 32'd4;
        end
        prev_valid = (if_valid === 1'b1);
        prev_fault = (fault === 1'b1);
        pv_instr = if_instr; pv_pc = if_pc; pv_plus4 = if_pc_plus4;

        if_ready = (c >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
        redirect_valid = (c < 200) && ($urandom_range(0, 11) == 0);
        if (redirect_valid) begin
          r = int'($urandom_range(0, 19));
          if (r < 14)      tgt = 32'($urandom_range(0, 6) * 4);
          else if (r < 17) tgt = 32'($urandom_range(0, 6) * 4 + $urandom_range(1, 3));
          else if (r < 19) tgt = 32'(28 + $urandom_range(0, 100) * 4);
          else             tgt = 32'hFFFF_FFFC;
          redirect_target = tgt;
          if (!prev_fault) exp_pc = tgt;
        end
        prev_redir = redirect_valid && !prev_fault;
        prev_ready = if_ready;
        mem_drive();
        @(negedge clk);
      end
      redirect_valid = 1'b0;
      vectors++; if ({fault, imem_req} !== 2'b10) begin miscompares++; $display("FAIL rnd_end e%0d: got %b%b want 10", ep, fault, imem_req); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    if_ready = 1'b0;
    rand_delay = 1'b0;
    delay_cfg = 0;
    wait_left = 0;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);

    test_reset();
    test_seq_zero_wait();
    test_wait_states();
    test_hold();
    test_redirect_ack();
    test_fault_end();
    test_misalign_and_reset();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
